mem_stage_wait: RTL and testbench

//  Pipeline MEM stage with a multi-cycle data memory. It replaces the single-cycle MEM stage.

---
 rtl/mem_stage_wait.sv | 131 +++++++++++++
 tb/tb_mem_stage_wait.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_stage_wait.sv
// MEM pipeline stage backed by a multi-cycle data memory.
// Pass-through fields go straight to MEM/WB; loads/stores hold ready low
// for WAIT_CYCLES cycles, then present results for one DONE cycle.
module mem_stage_wait #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 4,
  parameter int ADDR_BASE   = 1024,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [REG_W-1:0]  dest_in,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [REG_W-1:0]  dest_out,
  output logic [DATA_W-1:0] data_memory_out,
  output logic              ready,
  output logic              addr_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_req;
  logic [DATA_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;
  logic              w_bad;
  logic              w_access;

  // Control and ALU fields are not touched by this stage
  assign wb_en_out    = wb_en_in;
  assign mem_r_en_out = mem_r_en_in;
  assign alu_res_out  = alu_res_in;
  assign dest_out     = dest_in;

  assign w_req = mem_r_en_in | mem_w_en_in;

  // Byte address -> word index, plus range/alignment check
  assign w_off = alu_res_in - DATA_W'(ADDR_BASE);
  assign w_idx = w_off[IDX_W+1:2];
  assign w_bad = (alu_res_in < DATA_W'(ADDR_BASE)) | (w_off[1:0] != 2'b00)
               | ((w_off >> 2) >= DATA_W'(DEPTH));

  // The request cycle in IDLE already counts as the first stall cycle, so the
  // access edge is the one that ends the WAIT_CYCLES-th low cycle. With a single
  // wait cycle that is the IDLE edge itself and BUSY is skipped.
  assign w_access = ((r_state == S_IDLE) & w_req & (WAIT_CYCLES == 1))
                  | ((r_state == S_BUSY) & (r_cnt == '0));

  // Ready drops combinationally on a request and returns in DONE
  always_comb begin
    ready = 1'b1;
    case (r_state)
      S_IDLE:  ready = ~w_req;
      S_BUSY:  ready = 1'b0;
      default: ready = 1'b1;
    endcase
  end

  // Results are only visible during the DONE cycle
  always_comb begin
    data_memory_out = '0;
    addr_err        = 1'b0;
    if (r_state == S_DONE) begin
      data_memory_out = r_rdata;
      addr_err        = w_bad;
    end
  end

  // Stall FSM and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (WAIT_CYCLES == 1) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= CNT_W'(WAIT_CYCLES - 2);
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) r_state <= S_DONE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Load data register; stores (including r_en & w_en) and bad loads return 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_access) begin
      if (mem_w_en_in || w_bad) r_rdata <= '0;
      else                      r_rdata <= r_mem[w_idx];
    end
  end

  // Word array, cleared on reset, written only on a good store's access edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_access && mem_w_en_in && !w_bad) begin
      r_mem[w_idx] <= val_rm_in;
    end
  end

endmodule

// File: tb/tb_mem_stage_wait.sv
// Directed bench for mem_stage_wait (WAIT_CYCLES=3, ADDR_BASE=1024, DEPTH=64).
module tb_mem_stage_wait;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        wb_en_out, mem_r_en_out;
  logic [31:0] alu_res_out, data_memory_out;
  logic [3:0]  dest_out;
  logic        ready, addr_err;

  int checks = 0;
  int errors = 0;

  mem_stage_wait #(
    .DATA_W(32), .REG_W(4), .ADDR_BASE(1024), .DEPTH(64), .WAIT_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_res_out(alu_res_out), .dest_out(dest_out),
    .data_memory_out(data_memory_out), .ready(ready), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    mem_r_en_in = r;
    mem_w_en_in = w;
    alu_res_in  = a;
    val_rm_in   = d;
  endtask

  // Full memory op: 3 stall cycles, DONE cycle, then back to idle
  task automatic mem_op(input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input logic exp_err);
    set_in(r, w, a, d);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk({tag, "_stall_ready"}, {31'd0, ready}, 32'd0);
      chk({tag, "_stall_data"}, data_memory_out, 32'd0);
      tick();
    end
    #1;
    chk({tag, "_done_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, "_done_data"}, data_memory_out, exp_data);
    chk({tag, "_done_err"}, {31'd0, addr_err}, {31'd0, exp_err});
    $display("op %s r=%0b w=%0b addr=%0d data=%h err=%0b", tag, r, w, a, data_memory_out, addr_err);
    tick();
    set_in(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk({tag, "_after_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, "_after_data"}, data_memory_out, 32'd0);
    chk({tag, "_after_err"}, {31'd0, addr_err}, 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    wb_en_in = 1'b0;
    dest_in = 4'd0;
    set_in(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    #1;
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_data", data_memory_out, 32'd0);
    chk("reset_err", {31'd0, addr_err}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: pass-through in the same cycle
    wb_en_in = 1'b1; dest_in = 4'd3; alu_res_in = 32'h0000_0055;
    #1;
    chk("pt_wb_en", {31'd0, wb_en_out}, 32'd1);
    chk("pt_dest", {28'd0, dest_out}, 32'd3);
    chk("pt_alu", alu_res_out, 32'h0000_0055);
    chk("pt_r_en", {31'd0, mem_r_en_out}, 32'd0);
    chk("pt_ready", {31'd0, ready}, 32'd1);
    $display("passthrough wb=%0b dest=%0d alu=%h", wb_en_out, dest_out, alu_res_out);
    tick();
    wb_en_in = 1'b0; alu_res_in = 32'd0;

    // 2: store then load the same word
    mem_op("st1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'd0, 1'b0);
    mem_op("ld1028", 1'b1, 1'b0, 32'd1028, 32'd0, 32'hDEADBEEF, 1'b0);
    chk("ld_r_en_pt", {31'd0, mem_r_en_out}, 32'd0);

    // 3: ALU ops never stall
    wb_en_in = 1'b1; dest_in = 4'd5; alu_res_in = 32'h0000_1234;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("alu_ready", {31'd0, ready}, 32'd1);
      chk("alu_dest", {28'd0, dest_out}, 32'd5);
      chk("alu_data", data_memory_out, 32'd0);
      $display("alu cycle %0d ready=%0b dest=%0d", k, ready, dest_out);
      tick();
    end
    wb_en_in = 1'b0; dest_in = 4'd0; alu_res_in = 32'd0;

    // 4: bad addresses
    mem_op("ld1000", 1'b1, 1'b0, 32'd1000, 32'd0, 32'd0, 1'b1);
    mem_op("st1030", 1'b0, 1'b1, 32'd1030, 32'hCAFEF00D, 32'd0, 1'b1);
    mem_op("st1280", 1'b0, 1'b1, 32'd1280, 32'h11111111, 32'd0, 1'b1);
    mem_op("ld1028b", 1'b1, 1'b0, 32'd1028, 32'd0, 32'hDEADBEEF, 1'b0);
    mem_op("ld1276", 1'b1, 1'b0, 32'd1276, 32'd0, 32'd0, 1'b0);

    // 5: reset during stall aborts the store
    set_in(1'b0, 1'b1, 32'd1032, 32'h12345678);
    #1;
    chk("abort_ready0", {31'd0, ready}, 32'd0);
    tick();
    #1;
    chk("abort_ready1", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    set_in(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("abort_ready_rst", {31'd0, ready}, 32'd1);
    chk("abort_data_rst", data_memory_out, 32'd0);
    $display("abort ready=%0b", ready);
    tick();
    rst = 1'b0;
    tick();
    mem_op("ld1032", 1'b1, 1'b0, 32'd1032, 32'd0, 32'd0, 1'b0);
    mem_op("ld1028c", 1'b1, 1'b0, 32'd1028, 32'd0, 32'd0, 1'b0);

    // 6: both enables behave as a store
    mem_op("rw1036", 1'b1, 1'b1, 32'd1036, 32'hA5A5A5A5, 32'd0, 1'b0);
    mem_op("ld1036", 1'b1, 1'b0, 32'd1036, 32'd0, 32'hA5A5A5A5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
